multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
Multi-cycle instruction sequencer for the simple RISC-V core. It steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB. It takes decoded strobes from control_unit and gates the datapath write enables: IR, PC and register file. It also owns the single shared memory port handshake, with wait states, timeout and fault reporting.

Parameters:
MEM_TIMEOUT, 15, maximum wait cycles for mem_ready in FETCH or MEM before faulting (1..255)
CNT_W, 8, width of the internal wait counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  run request; sampled only in IDLE
opcode  in  7  instruction register [6:0]
Mem_R  in  1  load strobe from control_unit
Mem_W  in  1  store strobe from control_unit
Reg_W  in  1  register write strobe from control_unit
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write qualifier for mem_req
mem_is_fetch  out  1  address mux select: 1 = PC, 0 = ALU result
ir_we  out  1  latch instruction register
pc_we  out  1  commit next PC (PC+4 or target, selected by the datapath)
rf_we  out  1  gated register file write
state  out  3  current state encoding
halted  out  1  SYSTEM instruction reached
fault  out  1  sequencer stopped on an error
fault_code  out  2  00 none, 01 fetch timeout, 10 illegal instruction, 11 data timeout
instret  out  32  retired-instruction counter

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE, wait counter = 0, instret = 0, fault_code = 00.
  - All outputs 0.
  - Reset asserted mid-access aborts immediately; mem_req drops with no completion.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6, FAULT=7.
- Moore outputs: mem_req, mem_we, mem_is_fetch, halted, fault, state.
- Mealy outputs (same cycle as condition): ir_we, pc_we, rf_we.
- IDLE: start=1 -> FETCH. start is ignored in every other state.
- FETCH:
  - mem_req=1, mem_is_fetch=1, mem_we=0.
  - mem_ready=1: ir_we=1 that cycle -> DECODE.
  - mem_ready=0: counter++. Counter reaching MEM_TIMEOUT -> FAULT, code 01.
- DECODE (1 cycle):
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011.
  - 1110011 -> HALT.
  - Any other opcode outside the legal set -> FAULT, code 10.
  - Otherwise -> EXECUTE.
- EXECUTE (1 cycle):
  - Mem_R && Mem_W -> FAULT, code 10.
  - Mem_R or Mem_W -> MEM.
  - else Reg_W -> WB.
  - else (branch without link) pc_we=1, instret++ -> FETCH.
- MEM:
  - mem_req=1, mem_is_fetch=0, mem_we=Mem_W.
  - mem_ready with Mem_R -> WB.
  - mem_ready with store -> pc_we=1, instret++ -> FETCH.
  - Timeout as in FETCH -> FAULT, code 11.
- WB (1 cycle): rf_we=1, pc_we=1, instret++ -> FETCH.
- HALT and FAULT are terminal until rst. halted/fault are held high; fault_code is held.
- Wait counter clears on every entry to FETCH or MEM. mem_ready outside FETCH/MEM is ignored.
- instret wraps modulo 2^32.
- CPI with zero-wait memory: branch 3, store 4, ALU/JAL/LUI 4, load 5.
- Exactly one pc_we pulse per retired instruction. rf_we never asserts outside WB.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM);
  - the state encoding localparams;
  - the fault_code constants.
- One sub-module, mem_wait_timer: clear, enable, CNT_W counter and a `expired` flag at MEM_TIMEOUT. It is instantiated once and shared by FETCH and MEM.

Test Plan:
1. rst=0 asserted asynchronously mid-FETCH with mem_req=1 -> state=0, mem_req=0 and instret=0 before the next clk edge.
2. start pulse, opcode=0110011, Reg_W=1, mem_ready=1 -> state sequence 1,2,3,5,1; ir_we in cycle 1; rf_we=pc_we=1 in WB; instret=1.
3. opcode=0000011, Mem_R=1, mem_ready low for 3 MEM cycles -> mem_req=1 for 4 MEM cycles with mem_we=0, then WB; instret increments exactly once.
4. opcode=0100011, Mem_W=1 -> MEM with mem_we=1, then FETCH with pc_we=1 and rf_we never high; then opcode=1100011 with no strobes -> 3-cycle retire.
5. mem_ready held 0 in FETCH -> FAULT after 15 wait cycles, fault_code=01, mem_req=0, state stays 7 for 20 more cycles.
6. Two runs:
   - opcode=0000000 -> FAULT, fault_code=10.
   - After reset, opcode=1110011 -> HALT, halted=1, instret unchanged.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, sequencer state encoding and fault codes for the multi-cycle core
package riscv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_EXECUTE = 3'd3;
  localparam logic [2:0] S_MEM     = 3'd4;
  localparam logic [2:0] S_WB      = 3'd5;
  localparam logic [2:0] S_HALT    = 3'd6;
  localparam logic [2:0] S_FAULT   = 3'd7;
  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_FETCH   = 2'b01;
  localparam logic [1:0] FC_ILLEGAL = 2'b10;
  localparam logic [1:0] FC_DATA    = 2'b11;
  function automatic logic is_legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM};
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: wait-state counter shared by the FETCH and MEM accesses
// Ports: clk, rst (async, active-low), clr (zero the count), en (count one wait cycle),
//        expired (this enabled wait cycle brings the count to MEM_TIMEOUT)
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + CNT_W'(1);
  // flagged one cycle early so the FSM leaves on the wait cycle that reaches the limit
  assign expired = en && (cnt == CNT_W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXECUTE/MEM/WB control with memory handshake and fault reporting
// Ports: clk, rst (async, active-low), start, opcode, Mem_R/Mem_W/Reg_W strobes, mem_ready in;
//        mem_req/mem_we/mem_is_fetch memory control, ir_we/pc_we/rf_we datapath enables,
//        state, halted, fault, fault_code, instret out
module multicycle_sequencer import riscv_pkg::*; #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic        Mem_R,
  input  logic        Mem_W,
  input  logic        Reg_W,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_fetch,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [31:0] instret
);
  logic [2:0] state_nxt;
  logic [1:0] fc_nxt;
  logic in_access, expired;
  assign in_access = state == S_FETCH || state == S_MEM;
  // a completed access or leaving FETCH/MEM clears, so every entry starts from zero
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(!in_access || mem_ready),
    .en(in_access && !mem_ready),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= S_IDLE;
      fault_code <= FC_NONE;
      instret    <= '0;
    end else begin
      state      <= state_nxt;
      fault_code <= fc_nxt;
      instret    <= instret + {31'd0, pc_we};
    end
  always_comb begin
    state_nxt = state;
    fc_nxt    = fault_code;
    case (state)
      S_IDLE:    state_nxt = start ? S_FETCH : S_IDLE;
      S_FETCH:
        if (mem_ready) state_nxt = S_DECODE;
        else if (expired) begin
          state_nxt = S_FAULT;
          fc_nxt    = FC_FETCH;
        end
      S_DECODE:
        if (opcode == OP_SYSTEM) state_nxt = S_HALT;
        else if (!is_legal(opcode)) begin
          state_nxt = S_FAULT;
          fc_nxt    = FC_ILLEGAL;
        end else state_nxt = S_EXECUTE;
      S_EXECUTE:
        if (Mem_R && Mem_W) begin
          state_nxt = S_FAULT;
          fc_nxt    = FC_ILLEGAL;
        end else state_nxt = (Mem_R || Mem_W) ? S_MEM : Reg_W ? S_WB : S_FETCH;
      S_MEM:
        if (mem_ready) state_nxt = Mem_R ? S_WB : S_FETCH;
        else if (expired) begin
          state_nxt = S_FAULT;
          fc_nxt    = FC_DATA;
        end
      S_WB:      state_nxt = S_FETCH;
      default:   state_nxt = state;
    endcase
  end
  always_comb begin
    mem_req      = in_access;
    mem_is_fetch = state == S_FETCH;
    mem_we       = state == S_MEM && Mem_W;
    ir_we        = state == S_FETCH && mem_ready;
    rf_we        = state == S_WB;
    // every retire path commits the PC exactly once
    pc_we        = rf_we || (state == S_EXECUTE && !(Mem_R || Mem_W || Reg_W))
                   || (state == S_MEM && mem_ready && !Mem_R);
    halted       = state == S_HALT;
    fault        = state == S_FAULT;
  end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed and randomized checks against a per-instruction cycle/pulse model
module tb_multicycle_sequencer;
  import riscv_pkg::*;
  logic clk = 0, rst = 0, start = 0, Mem_R = 0, Mem_W = 0, Reg_W = 0, mem_ready = 0;
  logic [6:0] opcode = '0;
  logic mem_req, mem_we, mem_is_fetch, ir_we, pc_we, rf_we, halted, fault;
  logic [2:0] state;
  logic [1:0] fault_code;
  logic [31:0] instret;
  int n_assert = 0, n_fail = 0, exp_ret = 0;
  logic [31:0] trace;
  always #5 clk = ~clk;
  multicycle_sequencer #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .Mem_R(Mem_R), .Mem_W(Mem_W),
    .Reg_W(Reg_W), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_is_fetch(mem_is_fetch), .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
    .state(state), .halted(halted), .fault(fault), .fault_code(fault_code), .instret(instret)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic restart();
    rst = 0; start = 0; mem_ready = 0;
    #2 rst = 1;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    exp_ret = 0;
  endtask
  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // Runs one instruction starting in FETCH; memory answers after fw / mw wait cycles.
  // Expected values come from the CPI table plus wait states and the pulse rules per class.
  task automatic run_instr(input string tag, input logic [6:0] op, input logic r, input logic w,
                           input logic rw, input int cpi, input int fw, input int mw);
    int cyc = 0, pcs = 0, rfs = 0, irs = 0, ir_at = -1, memc = 0, wec = 0, wc = 0;
    bit done = 0;
    bit memop = r || w;
    opcode = op; Mem_R = r; Mem_W = w; Reg_W = rw; trace = '0;
    while (!done && cyc < 100) begin
      trace = {trace[28:0], state};
      mem_ready = mem_req && (wc == (mem_is_fetch ? fw : mw));
      #1;
      pcs += int'(pc_we); rfs += int'(rf_we); irs += int'(ir_we);
      if (ir_we && ir_at < 0) ir_at = cyc;
      if (mem_req && !mem_is_fetch) begin memc++; wec += int'(mem_we); end
      done = pc_we;
      wc = (mem_req && !mem_ready) ? wc + 1 : 0;
      @(posedge clk); #1;
      cyc++;
    end
    mem_ready = 0;
    exp_ret++;
    chk({tag, " cycles"}, cyc, cpi + fw + (memop ? mw : 0));
    chk({tag, " pc_we"}, pcs, 1);
    chk({tag, " ir_we"}, irs, 1);
    chk({tag, " ir_at"}, ir_at, fw);
    chk({tag, " rf_we"}, rfs, (r || (rw && !w)) ? 1 : 0);
    chk({tag, " data_req"}, memc, memop ? mw + 1 : 0);
    chk({tag, " mem_we"}, wec, w ? mw + 1 : 0);
    chk({tag, " instret"}, instret, exp_ret);
    chk({tag, " back_fetch"}, state, 1);
  endtask
  logic [6:0] ops [9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  int cpis [9] = '{4, 4, 5, 4, 3, 4, 4, 4, 4};
  initial begin
    #3;
    chk("rst state", state, 0);
    chk("rst outs", {mem_req, mem_we, mem_is_fetch, ir_we, pc_we, rf_we, halted, fault}, 0);
    chk("rst fcode", fault_code, 0);
    chk("rst instret", instret, 0);
    restart();
    chk("start fetch", state, 1);
    run_instr("alu", OP_R, 0, 0, 1, 4, 0, 0);
    chk("alu trace", trace[11:0], 12'o1235);
    run_instr("load", OP_LOAD, 1, 0, 1, 5, 0, 3);
    run_instr("store", OP_STORE, 0, 1, 0, 4, 0, 0);
    run_instr("branch", OP_BRANCH, 0, 0, 0, 3, 0, 0);
    chk("branch trace", trace[8:0], 9'o123);
    for (int i = 0; i < 40; i++) begin
      int k = $urandom_range(0, 8);
      int fw = $urandom_range(0, 14);
      int mw = $urandom_range(0, 14);
      logic r = ops[k] == OP_LOAD;
      logic w = ops[k] == OP_STORE;
      logic rw = !(w || ops[k] == OP_BRANCH);
      run_instr("rand", ops[k], r, w, rw, cpis[k], fw, mw);
    end
    mem_ready = 0;
    #2 rst = 0;
    #1;
    chk("async rst state", state, 0);
    chk("async rst req", mem_req, 0);
    chk("async rst instret", instret, 0);
    restart();
    clocks(14);
    chk("fetch wait14", state, 1);
    clocks(1);
    chk("fetch to state", state, 7);
    chk("fetch to code", fault_code, 1);
    chk("fetch to req", mem_req, 0);
    chk("fetch to fault", fault, 1);
    begin
      bit bad = 0;
      for (int i = 0; i < 20; i++) begin
        start = i[0]; mem_ready = i[1];
        clocks(1);
        bad |= (state !== 3'd7) || (fault !== 1'b1) || (fault_code !== 2'b01);
      end
      start = 0; mem_ready = 0;
      chk("fault hold", bad, 0);
    end
    restart();
    opcode = OP_LOAD; Mem_R = 1; Mem_W = 0; Reg_W = 1; mem_ready = 1;
    clocks(1);
    mem_ready = 0;
    clocks(2);
    chk("mem entry", state, 4);
    clocks(14);
    chk("mem wait14", state, 4);
    clocks(1);
    chk("data to state", state, 7);
    chk("data to code", fault_code, 3);
    chk("data to instret", instret, 0);
    restart();
    opcode = OP_R; Mem_R = 1; Mem_W = 1; Reg_W = 0; mem_ready = 1;
    clocks(3);
    chk("rw conflict state", state, 7);
    chk("rw conflict code", fault_code, 2);
    restart();
    opcode = 7'b0000000; Mem_R = 0; Mem_W = 0; Reg_W = 0; mem_ready = 1;
    clocks(2);
    chk("illegal state", state, 7);
    chk("illegal code", fault_code, 2);
    restart();
    opcode = OP_SYSTEM; mem_ready = 1;
    clocks(2);
    mem_ready = 0;
    chk("halt state", state, 6);
    chk("halt flag", halted, 1);
    chk("halt instret", instret, 0);
    start = 1;
    clocks(3);
    start = 0;
    chk("halt hold", {halted, fault, state}, {1'b1, 1'b0, 3'd6});
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
